// File: rtl/reg_bank_sb_if.sv
// Bus bundle for reg_bank_sb: bus write, two read ports, load issue/retire
// and scoreboard status. slave = register bank, master = control/datapath.
interface reg_bank_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
);
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  rd_a_idx;
    logic              ba_out;
    logic [DATA_W-1:0] rd_a_data;
    logic [IDX_W-1:0]  rd_b_idx;
    logic [DATA_W-1:0] rd_b_data;
    logic              ld_issue;
    logic [IDX_W-1:0]  ld_idx;
    logic              ld_ack;
    logic              ld_done;
    logic [DATA_W-1:0] ld_data;
    logic [NUM_REGS-1:0] busy;
    logic              stall;
    logic [IDX_W:0]    pending_cnt;
    logic              hazard_err;

    modport slave (
        input  wr_en, wr_idx, wr_data,
        input  rd_a_idx, ba_out, rd_b_idx,
        input  ld_issue, ld_idx, ld_done, ld_data,
        output rd_a_data, rd_b_data, ld_ack,
        output busy, stall, pending_cnt, hazard_err
    );

    modport master (
        output wr_en, wr_idx, wr_data,
        output rd_a_idx, ba_out, rd_b_idx,
        output ld_issue, ld_idx, ld_done, ld_data,
        input  rd_a_data, rd_b_data, ld_ack,
        input  busy, stall, pending_cnt, hazard_err
    );
endinterface

// File: rtl/reg_bank_sb.sv
// Register bank with in-order load scoreboard (busy bits + index FIFO).
// Ports: clock, clear (sync active-high), bus (reg_bank_sb_if.slave).
module reg_bank_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int LD_DEPTH = 4
) (
    input  logic         clock,
    input  logic         clear,
    reg_bank_sb_if.slave bus
);
    localparam int PTR_W = $clog2(LD_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LD_DEPTH);
    localparam logic [CNT_W-1:0] NREG_C  = CNT_W'(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [IDX_W-1:0]    fifo_q [LD_DEPTH];
    logic [IDX_W-1:0]    fifo_d [LD_DEPTH];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic a_ok, a_base, b_ok, wr_ok, ld_ok;
    logic ack, pop, wr_go;
    logic [IDX_W-1:0] head_idx;

    function automatic logic idx_ok(input logic [IDX_W-1:0] i);
        return {1'b0, i} < NREG_C;
    endfunction

    always_comb begin
        a_ok     = idx_ok(bus.rd_a_idx);
        a_base   = bus.ba_out && (bus.rd_a_idx == '0);
        b_ok     = idx_ok(bus.rd_b_idx);
        wr_ok    = idx_ok(bus.wr_idx);
        ld_ok    = idx_ok(bus.ld_idx);
        head_idx = fifo_q[head_q];

        // Issue decision uses pre-edge count: a same-cycle retire
        // does not free a slot for this issue.
        ack = bus.ld_issue && (cnt_q < DEPTH_C) && ld_ok
              && !busy_q[bus.ld_idx];
        pop = bus.ld_done && (cnt_q != '0);
        // A busy destination also covers the same-cycle retire case.
        wr_go = bus.wr_en && wr_ok && !busy_q[bus.wr_idx];

        regs_d = regs_q;
        fifo_d = fifo_q;
        busy_d = busy_q;
        head_d = head_q;
        tail_d = tail_q;
        err_d  = err_q;

        if (wr_go)
            regs_d[bus.wr_idx] = bus.wr_data;
        if (pop) begin
            regs_d[head_idx] = bus.ld_data;
            busy_d[head_idx] = 1'b0;
            head_d = head_q + 1'b1;
        end
        if (ack) begin
            fifo_d[tail_q]     = bus.ld_idx;
            busy_d[bus.ld_idx] = 1'b1;
            tail_d = tail_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(ack) - CNT_W'(pop);

        if (bus.wr_en && !wr_go)
            err_d = 1'b1;
        if (bus.ld_issue && !ld_ok)
            err_d = 1'b1;
        if (bus.ld_done && !pop)
            err_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            for (int i = 0; i < LD_DEPTH; i++)
                fifo_q[i] <= '0;
            busy_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            fifo_q <= fifo_d;
            busy_q <= busy_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        bus.rd_a_data = '0;
        bus.rd_b_data = '0;
        if (a_ok && !a_base)
            bus.rd_a_data = regs_q[bus.rd_a_idx];
        if (b_ok)
            bus.rd_b_data = regs_q[bus.rd_b_idx];
        bus.stall = (a_ok && !a_base && busy_q[bus.rd_a_idx])
                  || (b_ok && busy_q[bus.rd_b_idx]);
    end

    assign bus.ld_ack      = ack;
    assign bus.busy        = busy_q;
    assign bus.pending_cnt = cnt_q;
    assign bus.hazard_err  = err_q;
endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench for reg_bank_sb: reference model pushes expected
// outputs per cycle; a negedge monitor pops and compares.
module tb_reg_bank_sb;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int IW = 4;
    localparam int LD = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    reg_bank_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW)) bus ();

    reg_bank_sb #(
        .DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .LD_DEPTH(LD)
    ) dut (
        .clock(clk),
        .clear(clr),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          ack;
        logic [NR-1:0] busy;
        logic          stall;
        logic [IW:0]   cnt;
        logic          err;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    logic [DW-1:0] m_regs [NR];
    int            m_q[$];
    bit            m_err;

    function automatic bit m_busy(int i);
        foreach (m_q[k])
            if (m_q[k] == i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_q.delete();
        m_err = 1'b0;
    endfunction

    function automatic void predict(output exp_t e);
        int ai, bi, li;
        bit abase;
        ai = int'(bus.rd_a_idx);
        bi = int'(bus.rd_b_idx);
        li = int'(bus.ld_idx);
        abase = bus.ba_out && (ai == 0);
        e.a = abase ? '0 : m_regs[ai];
        e.b = m_regs[bi];
        e.ack = bus.ld_issue && (m_q.size() < LD) && !m_busy(li);
        for (int i = 0; i < NR; i++) e.busy[i] = m_busy(i);
        e.stall = (!abase && m_busy(ai)) || m_busy(bi);
        e.cnt = (IW+1)'(m_q.size());
        e.err = m_err;
    endfunction

    function automatic void m_update(bit ack);
        int h;
        if (clr) begin
            m_reset();
            return;
        end
        if (bus.wr_en) begin
            if (m_busy(int'(bus.wr_idx))) m_err = 1'b1;
            else m_regs[int'(bus.wr_idx)] = bus.wr_data;
        end
        if (bus.ld_done) begin
            if (m_q.size() == 0) m_err = 1'b1;
            else begin
                h = m_q.pop_front();
                m_regs[h] = bus.ld_data;
            end
        end
        if (ack) m_q.push_back(int'(bus.ld_idx));
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rd_a_data", bus.rd_a_data, e.a);
            chk("rd_b_data", bus.rd_b_data, e.b);
            chk("ld_ack", DW'(bus.ld_ack), DW'(e.ack));
            chk("busy", DW'(bus.busy), DW'(e.busy));
            chk("stall", DW'(bus.stall), DW'(e.stall));
            chk("pending_cnt", DW'(bus.pending_cnt), DW'(e.cnt));
            chk("hazard_err", DW'(bus.hazard_err), DW'(e.err));
        end
    end

    task automatic idle();
        clr = 1'b0;
        bus.wr_en = 1'b0;   bus.wr_idx = '0;  bus.wr_data = '0;
        bus.rd_a_idx = '0;  bus.ba_out = 1'b0; bus.rd_b_idx = '0;
        bus.ld_issue = 1'b0; bus.ld_idx = '0;
        bus.ld_done = 1'b0; bus.ld_data = '0;
    endtask

    task automatic step();
        exp_t e;
        predict(e);
        sbq.push_back(e);
        @(posedge clk);
        m_update(e.ack);
        #1;
    endtask

    task automatic wr(int idx, logic [DW-1:0] d);
        bus.wr_en = 1'b1; bus.wr_idx = IW'(idx); bus.wr_data = d;
    endtask

    task automatic iss(int idx);
        bus.ld_issue = 1'b1; bus.ld_idx = IW'(idx);
    endtask

    task automatic done(logic [DW-1:0] d);
        bus.ld_done = 1'b1; bus.ld_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        m_reset();
        #1;
        idle(); step();

        idle(); wr(5, 32'hDEADBEEF); bus.rd_a_idx = 4'd5; step();
        idle(); bus.rd_a_idx = 4'd5; step();

        idle(); wr(0, 32'h100); step();
        idle(); bus.ba_out = 1'b1; step();
        idle(); step();

        idle(); iss(3); step();
        idle(); iss(7); step();
        idle(); iss(3); step();
        idle(); bus.rd_b_idx = 4'd7; bus.rd_a_idx = 4'd3; step();
        idle(); done(32'h11); step();
        idle(); done(32'h22); bus.rd_a_idx = 4'd7; step();
        idle(); bus.rd_a_idx = 4'd3; bus.rd_b_idx = 4'd7; step();

        for (int i = 1; i <= 4; i++) begin
            idle(); iss(i); step();
        end
        idle(); iss(5); done(32'hA1); step();
        idle(); iss(5); step();
        for (int i = 0; i < 4; i++) begin
            idle(); done(32'hB0 + DW'(i)); step();
        end
        for (int i = 1; i <= 5; i++) begin
            idle(); bus.rd_a_idx = IW'(i); bus.rd_b_idx = IW'(i); step();
        end

        idle(); iss(9); step();
        idle(); wr(9, 32'h55); bus.rd_b_idx = 4'd9; step();
        idle(); wr(9, 32'hAA); done(32'hBB); step();
        idle(); bus.rd_a_idx = 4'd9; step();

        idle(); iss(1); step();
        idle(); iss(2); step();
        idle(); clr = 1'b1; step();
        idle(); done(32'hCC); step();
        idle(); bus.rd_a_idx = 4'd1; bus.rd_b_idx = 4'd2; step();

        for (int n = 0; n < 600; n++) begin
            idle();
            bus.rd_a_idx = IW'($urandom_range(0, NR-1));
            bus.rd_b_idx = IW'($urandom_range(0, NR-1));
            bus.ba_out = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 35)
                wr($urandom_range(0, NR-1), $urandom);
            if ($urandom_range(0, 99) < 40)
                iss($urandom_range(0, NR-1));
            if ($urandom_range(0, 99) < 35)
                done($urandom);
            if ($urandom_range(0, 199) == 0)
                clr = 1'b1;
            step();
        end

        idle();
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
